// File: rtl/ac97_link_pkg.sv
// ac97_link_pkg: AC-link command widths, arbiter states and the LM4550 register map
package ac97_link_pkg;
  localparam int SLOT_W = 20;
  localparam int TAG_W = 2;
  localparam int TAG_SLOT1_BIT = 14;
  localparam int TAG_SLOT2_BIT = 13;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] RD_TIMEOUT_DATA = 16'hFFFF;
  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_RD, COMPLETE} cmd_state_t;
  localparam int NUM_VALID = 22;
  localparam logic [ADDR_W-1:0] VALID_ADDRS [NUM_VALID] = '{
    7'h00, 7'h02, 7'h04, 7'h06, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h12, 7'h14, 7'h16,
    7'h18, 7'h1A, 7'h1C, 7'h20, 7'h26, 7'h28, 7'h2A, 7'h2C, 7'h32, 7'h7C, 7'h7E
  };
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = 1'b0;
    for (int i = 0; i < NUM_VALID; i++) if (VALID_ADDRS[i] == a) addr_ok = 1'b1;
  endfunction
endpackage

// File: rtl/ac97_cmd_arbiter_rr.sv
// rr_arbiter: round-robin pick starting after the last granted requester
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            BIT_CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic            any,
  output logic [IW-1:0]   pick
);
  logic [IW-1:0] last;
  always_comb begin
    pick = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(last) + k) % NREQ]) pick = IW'((int'(last) + k) % NREQ);
  end
  assign any = |req;
  always_ff @(posedge BIT_CLK or posedge RESET)
    if (RESET) last <= IW'(NREQ - 1);
    else if (upd) last <= pick;
endmodule

// File: rtl/ac97_cmd_arbiter.sv
// ac97_cmd_arbiter: shares the AC-link command slots round-robin and matches read status.
// Define AC97_CMD_ADDR_FILTER_EN to reject addresses outside the LM4550 register map.
module ac97_cmd_arbiter import ac97_link_pkg::*; #(
  parameter int NREQ = 2,
  parameter int RD_TIMEOUT = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                   BIT_CLK,
  input  logic                   RESET,
  input  logic                   SYNC,
  input  logic                   CODEC_READY,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_RW,
  input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0] REQ_DATA,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        DONE,
  output logic [DATA_W-1:0]      RD_DATA,
  output logic                   ERR,
  output logic                   SLOT_VALID,
  output logic [TAG_W-1:0]       SLOT_TAG,
  output logic [SLOT_W-1:0]      SLOT1,
  output logic [SLOT_W-1:0]      SLOT2,
  input  logic                   STS_VALID,
  input  logic [ADDR_W-1:0]      STS_ADDR,
  input  logic [DATA_W-1:0]      STS_DATA
);
  cmd_state_t st, st_n;
  logic sync_q, fs, sent, rw_q, any, ok, match, tmo, err_n;
  logic [IW-1:0] pick, idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0] cnt;
  assign fs = SYNC & ~sync_q;
  assign match = STS_VALID && STS_ADDR == addr_q;
  assign tmo = fs && cnt + 4'd1 == 4'(RD_TIMEOUT);
`ifdef AC97_CMD_ADDR_FILTER_EN
  assign ok = addr_ok(REQ_ADDR[pick*ADDR_W +: ADDR_W]);
`else
  assign ok = 1'b1;
`endif
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .BIT_CLK(BIT_CLK),
    .RESET(RESET),
    .req(REQ),
    .upd(st == ARB && any),
    .any(any),
    .pick(pick)
  );
  assign GNT = st == ARB && any ? NREQ'(1) << pick : '0;
  assign DONE = st == COMPLETE ? NREQ'(1) << idx_q : '0;
  always_comb begin
    st_n = st;
    err_n = 1'b0;
    case (st)
      IDLE: st_n = CODEC_READY && any ? ARB : IDLE;
      ARB: begin
        st_n = !any ? IDLE : ok ? ISSUE : COMPLETE;
        err_n = any && !ok;
      end
      ISSUE: st_n = fs && sent ? (rw_q ? WAIT_RD : COMPLETE) : ISSUE;
      WAIT_RD: begin
        st_n = match || tmo ? COMPLETE : WAIT_RD;
        err_n = tmo && !match;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge BIT_CLK or posedge RESET)
    if (RESET) st <= IDLE;
    else st <= st_n;
  // sent marks the frame whose slots are on air; the next FS retires them
  always_ff @(posedge BIT_CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= 1'b0;
      sent <= 1'b0;
      rw_q <= 1'b0;
      idx_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      RD_DATA <= '0;
      ERR <= 1'b0;
      SLOT_VALID <= 1'b0;
      SLOT_TAG <= '0;
      SLOT1 <= '0;
      SLOT2 <= '0;
    end else begin
      sync_q <= SYNC;
      ERR <= err_n;
      if (st == ARB && any) begin
        rw_q <= REQ_RW[pick];
        addr_q <= REQ_ADDR[pick*ADDR_W +: ADDR_W];
        data_q <= REQ_DATA[pick*DATA_W +: DATA_W];
        idx_q <= pick;
      end
      if (st == ISSUE && fs) begin
        sent <= !sent;
        SLOT_VALID <= !sent;
        SLOT_TAG <= sent ? '0 : {1'b1, !rw_q};
        SLOT1 <= sent ? '0 : {rw_q, addr_q, 12'd0};
        SLOT2 <= sent || rw_q ? '0 : {data_q, 4'd0};
        cnt <= '0;
      end
      if (st == WAIT_RD) begin
        cnt <= fs ? cnt + 4'd1 : cnt;
        RD_DATA <= match ? STS_DATA : tmo ? RD_TIMEOUT_DATA : RD_DATA;
      end
    end
  end
endmodule

// File: tb/tb_ac97_cmd_arbiter.sv
// tb_ac97_cmd_arbiter: directed and randomized command traffic checked against a frame-timeline model
module tb_ac97_cmd_arbiter;
  import ac97_link_pkg::*;
  localparam int NREQ = 2, TMO = 4, FR = 16;
  logic BIT_CLK = 1'b0, RESET = 1'b1, SYNC, CODEC_READY = 1'b0, STS_VALID = 1'b0;
  logic [NREQ-1:0] REQ = '0, REQ_RW = '0, GNT, DONE;
  logic [NREQ*7-1:0] REQ_ADDR = '0;
  logic [NREQ*16-1:0] REQ_DATA = '0;
  logic [15:0] RD_DATA, STS_DATA = '0, rd_exp = '0;
  logic [6:0] STS_ADDR = '0;
  logic ERR, SLOT_VALID;
  logic [1:0] SLOT_TAG;
  logic [19:0] SLOT1, SLOT2;
  int fc = 0, total = 0, bad = 0, last_m = NREQ - 1;

  ac97_cmd_arbiter #(.NREQ(NREQ), .RD_TIMEOUT(TMO)) dut (
    .BIT_CLK(BIT_CLK), .RESET(RESET), .SYNC(SYNC), .CODEC_READY(CODEC_READY),
    .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .DONE(DONE), .RD_DATA(RD_DATA), .ERR(ERR),
    .SLOT_VALID(SLOT_VALID), .SLOT_TAG(SLOT_TAG), .SLOT1(SLOT1), .SLOT2(SLOT2),
    .STS_VALID(STS_VALID), .STS_ADDR(STS_ADDR), .STS_DATA(STS_DATA)
  );

  always #5 BIT_CLK = ~BIT_CLK;
  // short frames keep the run brief; SYNC rises where fc wraps to 0
  always @(posedge BIT_CLK) fc <= (fc + 1) % FR;
  assign SYNC = fc < 2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({SLOT_VALID, SLOT_TAG, SLOT1, SLOT2, DONE, ERR});
  endfunction

  function automatic logic [63:0] want(input logic [42:0] f, input logic [NREQ-1:0] dn, input bit e);
    return 64'({f, dn, e});
  endfunction

  task automatic set_req(input int r, input bit rw, input logic [6:0] a, input logic [15:0] d);
    REQ[r] = 1'b1;
    REQ_RW[r] = rw;
    REQ_ADDR[r*7 +: 7] = a;
    REQ_DATA[r*16 +: 16] = d;
  endtask

  task automatic wait_gnt(input int r);
    int n = 0;
    do begin @(negedge BIT_CLK); n++; end while (GNT === '0 && n < 8*FR);
    chk("gnt", 64'(GNT), 64'(1) << r);
    last_m = r;
  endtask

  // Walks the frame timeline from the grant cycle: wait for a frame start, slots on air
  // for one frame, then completion (write) or status/timeout handling (read).
  task automatic run_body(input int r, input bit rw, input logic [6:0] a, input logic [15:0] d,
                          input int mode, input int w, input logic [6:0] sa, input logic [15:0] sd);
    logic [42:0] f;
    int ph, nfs, k;
    bit eerr, send;
    ph = 0; nfs = 0; k = 0; eerr = 1'b0;
    f = {1'b1, 1'b1, !rw, rw, a, 12'd0, (rw ? 20'd0 : {d, 4'd0})};
    for (int n = 0; n < 12*FR && ph != 4; n++) begin
      @(negedge BIT_CLK);
      STS_VALID = 1'b0;
      case (ph)
        0: begin
          chk("pre_issue", outs(), want('0, '0, 1'b0));
          if (fc == 0) ph = 1;
        end
        1: begin
          chk("slot", outs(), want(f, '0, 1'b0));
          if (fc == 0) ph = rw ? 2 : 3;
        end
        2: begin
          chk("wait_rd", outs(), want('0, '0, 1'b0));
          if (fc == 0) nfs++;
          send = mode == 2 ? (fc == 0 && nfs == w) : (mode == 1 && k == w);
          k++;
          if (send) begin STS_VALID = 1'b1; STS_ADDR = sa; STS_DATA = sd; end
          if (send && sa == a) begin rd_exp = sd; ph = 3; end
          else if (fc == 0 && nfs == TMO) begin rd_exp = 16'hFFFF; eerr = 1'b1; ph = 3; end
        end
        default: begin
          chk("done", outs(), want('0, NREQ'(1) << r, eerr));
          chk("rd_data", 64'(RD_DATA), 64'(rd_exp));
          ph = 4;
        end
      endcase
    end
    if (ph != 4) chk("bound", 64'(ph), 64'd4);
  endtask

  task automatic run_cmd(input int r, input bit rw, input logic [6:0] a, input logic [15:0] d,
                         input int mode, input int w, input logic [6:0] sa, input logic [15:0] sd);
    set_req(r, rw, a, d);
    wait_gnt(r);
    run_body(r, rw, a, d, mode, w, sa, sd);
    REQ[r] = 1'b0;
  endtask

  initial begin
    int r, mode, w, e;
    bit rw, seen;
    logic [6:0] a, sa;
    logic [15:0] d;
    repeat (3) @(negedge BIT_CLK);
    chk("reset_out", outs(), 64'd0);
    chk("reset_gnt", 64'({GNT, RD_DATA}), 64'd0);
    RESET = 1'b0;
    CODEC_READY = 1'b1;
    run_cmd(0, 1'b0, 7'h02, 16'h8000, 0, 0, 7'h00, 16'h0000);
    run_cmd(1, 1'b1, 7'h26, 16'h0000, 2, 2, 7'h26, 16'h000F);
    run_cmd(0, 1'b1, 7'h1C, 16'h0000, 0, 0, 7'h00, 16'h0000);
    run_cmd(1, 1'b1, 7'h1C, 16'h0000, 2, TMO, 7'h1C, 16'h1234);
    run_cmd(0, 1'b1, 7'h18, 16'h0000, 1, 3, 7'h1A, 16'h4321);
    // both requesters held high: grants must alternate
    set_req(0, 1'b0, 7'h10, 16'hA5A5);
    set_req(1, 1'b0, 7'h12, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      e = (last_m + 1) % NREQ;
      wait_gnt(e);
      run_body(e, 1'b0, e == 1 ? 7'h12 : 7'h10, e == 1 ? 16'h5A5A : 16'hA5A5, 0, 0, 7'h00, 16'h0000);
    end
    REQ = '0;
    CODEC_READY = 1'b0;
    set_req(0, 1'b0, 7'h04, 16'h1111);
    seen = 1'b0;
    repeat (3*FR) begin @(negedge BIT_CLK); seen |= (GNT !== '0); end
    chk("gated", 64'(seen), 64'd0);
    CODEC_READY = 1'b1;
    wait_gnt(0);
    run_body(0, 1'b0, 7'h04, 16'h1111, 0, 0, 7'h00, 16'h0000);
    REQ = '0;
    set_req(1, 1'b0, 7'h0A, 16'h5555);
    wait_gnt(1);
    for (int n = 0; n < 3*FR && SLOT_VALID !== 1'b1; n++) @(negedge BIT_CLK);
    chk("slot_before_rst", 64'(SLOT_VALID), 64'd1);
    RESET = 1'b1;
    #1;
    chk("rst_slot", outs(), 64'd0);
    rd_exp = '0;
    last_m = NREQ - 1;
    REQ = '0;
    @(negedge BIT_CLK);
    RESET = 1'b0;
    seen = 1'b0;
    repeat (3*FR) begin @(negedge BIT_CLK); seen |= (DONE !== '0) || (SLOT_VALID !== 1'b0); end
    chk("rst_no_done", 64'(seen), 64'd0);
    chk("rst_rd", 64'(RD_DATA), 64'd0);
`ifdef AC97_CMD_ADDR_FILTER_EN
    set_req(0, 1'b0, 7'h08, 16'h2468);
    wait_gnt(0);
    @(negedge BIT_CLK);
    chk("filt_done", outs(), want('0, NREQ'(1), 1'b1));
    chk("filt_rd", 64'(RD_DATA), 64'(rd_exp));
    REQ = '0;
    seen = 1'b0;
    repeat (2*FR) begin @(negedge BIT_CLK); seen |= (SLOT_VALID !== 1'b0) || (DONE !== '0); end
    chk("filt_quiet", 64'(seen), 64'd0);
`else
    run_cmd(0, 1'b0, 7'h08, 16'h2468, 0, 0, 7'h00, 16'h0000);
`endif
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, NREQ - 1);
      rw = 1'($urandom_range(0, 1));
      a = VALID_ADDRS[$urandom_range(0, NUM_VALID - 1)];
      d = 16'($urandom);
      mode = rw ? $urandom_range(0, 2) : 0;
      w = mode == 2 ? $urandom_range(1, TMO + 1) : $urandom_range(0, TMO*FR);
      sa = $urandom_range(0, 3) == 0 ? a ^ 7'h02 : a;
      run_cmd(r, rw, a, d, mode, w, sa, 16'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
